// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, widths and challenge-to-pair mapping
// for the ring-oscillator PUF evaluator.
package puf_pkg;

  localparam int unsigned MAX_CHAL_W  = 64;
  localparam int unsigned MAX_CHAL_IW = $clog2(MAX_CHAL_W);
  localparam int unsigned MAX_IDX_W   = 16;
  localparam int unsigned MAX_IDX_IW  = $clog2(MAX_IDX_W);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, COUNT, CMP, DONE} state_t;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] a;
    logic [MAX_IDX_W-1:0] b;
  } pair_t;

  // Oscillator index width for a given array size.
  function automatic int unsigned idx_width(input int unsigned num_ro);
    return (num_ro < 2) ? 1 : $clog2(num_ro);
  endfunction

  // Rotate the challenge left by i (caller keeps i < chal_w), take the two
  // lowest index fields as the pair, and never let a pair compare with itself.
  function automatic pair_t pair_sel(input logic [MAX_CHAL_W-1:0] chall,
                                     input int unsigned i,
                                     input int unsigned chal_w,
                                     input int unsigned idx_w);
    logic [MAX_CHAL_W-1:0] k;
    pair_t p;
    k = '0;
    for (int unsigned j = 0; j < MAX_CHAL_W; j++) begin
      if (j < chal_w) begin
        if (j >= i) k[MAX_CHAL_IW'(j)] = chall[MAX_CHAL_IW'(j - i)];
        else        k[MAX_CHAL_IW'(j)] = chall[MAX_CHAL_IW'(j + chal_w - i)];
      end
    end
    p = '0;
    for (int unsigned m = 0; m < MAX_IDX_W; m++) begin
      if (m < idx_w) begin
        p.a[MAX_IDX_IW'(m)] = k[MAX_CHAL_IW'(m)];
        p.b[MAX_IDX_IW'(m)] = k[MAX_CHAL_IW'(m + idx_w)];
      end
    end
    if (p.a == p.b) begin
      p.b    = p.a;
      p.b[0] = ~p.a[0];
    end
    return p;
  endfunction

endpackage

// File: rtl/ro_puf_eval_if.sv
// ro_puf_eval_if: host-side start/challenge/response handshake of the PUF evaluator.
interface ro_puf_eval_if #(
  parameter int unsigned CHAL_W = 8,
  parameter int unsigned RESP_W = 8
);
  logic              en;
  logic [CHAL_W-1:0] chall_in;
  logic [RESP_W-1:0] response;
  logic              ready;
  logic              busy;

  modport master (output en, chall_in, input response, ready, busy);
  modport slave  (input en, chall_in, output response, ready, busy);
endinterface

// File: rtl/puf_edge_counter.sv
// puf_edge_counter: rising-edge detector plus saturating counter for one
// selected, already synchronized oscillator.
module puf_edge_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             sys_rst_neg,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             sig,
  output logic [CNT_W-1:0] cnt
);

  logic sig_d;

  // Previous sample of the selected oscillator for edge detection.
  always_ff @(posedge clk or negedge sys_rst_neg) begin
    if (!sys_rst_neg) sig_d <= 1'b0;
    else              sig_d <= sig;
  end

  // Count rising edges inside the window, sticking at all-ones.
  always_ff @(posedge clk or negedge sys_rst_neg) begin
    if (!sys_rst_neg)                          cnt <= '0;
    else if (clr)                              cnt <= '0;
    else if (cnt_en && sig && !sig_d && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ro_puf_eval.sv
// ro_puf_eval: ring-oscillator PUF evaluator. Per response bit, counts the
// rising edges of two challenge-selected oscillators over a fixed window
// and records whether the first one is faster.
// Optional feature: define PUF_MAJORITY_VOTE_EN to evaluate every bit VOTES
// times and keep the majority result.
module ro_puf_eval
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W = 8,
  parameter int unsigned RESP_W = 8,
  parameter int unsigned NUM_RO = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 64,
  parameter int unsigned VOTES  = 3
) (
  input  logic              clk,
  input  logic              sys_rst_neg,
  input  logic [NUM_RO-1:0] ro_in,
  ro_puf_eval_if.slave      host
);

  localparam int unsigned IDX_W = idx_width(NUM_RO);
  localparam int unsigned ROT_W = $clog2(CHAL_W);
  localparam int unsigned BIT_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int unsigned WIN_W = $clog2(WINDOW);

  state_t            state, next_state;
  logic [NUM_RO-1:0] sync1, sync2;
  logic [CHAL_W-1:0] chall_reg;
  logic [ROT_W-1:0]  rot_amt;
  logic [BIT_W-1:0]  bit_idx;
  logic [WIN_W-1:0]  win_cnt;
  logic [RESP_W-1:0] result_reg, final_vec, response;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic [IDX_W-1:0]  sel_a, sel_b;
  pair_t             pair;
  logic              cmp_gt, bit_val, last_eval, last_bit, win_last, advance;
  logic              unused_pair_bits;

  // Two-flop synchronizer on every raw oscillator line.
  always_ff @(posedge clk or negedge sys_rst_neg) begin
    if (!sys_rst_neg) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
    end
  end

  assign pair      = pair_sel(MAX_CHAL_W'(chall_reg), 32'(rot_amt), CHAL_W, IDX_W);
  assign sel_a     = pair.a[IDX_W-1:0];
  assign sel_b     = pair.b[IDX_W-1:0];
  assign unused_pair_bits = ^{pair.a[MAX_IDX_W-1:IDX_W], pair.b[MAX_IDX_W-1:IDX_W]};

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .sys_rst_neg(sys_rst_neg), .clr(state == CLEAR),
    .cnt_en(state == COUNT), .sig(sync2[sel_a]), .cnt(cnt_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .sys_rst_neg(sys_rst_neg), .clr(state == CLEAR),
    .cnt_en(state == COUNT), .sig(sync2[sel_b]), .cnt(cnt_b)
  );

  assign cmp_gt   = (cnt_a > cnt_b);
  assign win_last = (win_cnt == WIN_W'(WINDOW - 1));
  assign last_bit = (bit_idx == BIT_W'(RESP_W - 1));
  assign advance  = (state == CMP) && host.en && last_eval;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int unsigned VOTE_W  = $clog2(VOTES);
  localparam int unsigned TALLY_W = $clog2(VOTES + 1);

  logic [VOTE_W-1:0]  vote_idx;
  logic [TALLY_W-1:0] tally, tally_next;

  assign tally_next = tally + TALLY_W'(cmp_gt);
  assign last_eval  = (vote_idx == VOTE_W'(VOTES - 1));
  assign bit_val    = (tally_next > TALLY_W'(VOTES / 2));

  // Vote index and running count of 1-results for the bit being evaluated.
  always_ff @(posedge clk or negedge sys_rst_neg) begin
    if (!sys_rst_neg) begin
      vote_idx <= '0;
      tally    <= '0;
    end else if (state == IDLE && host.en) begin
      vote_idx <= '0;
      tally    <= '0;
    end else if (state == CMP && host.en) begin
      if (last_eval) begin
        vote_idx <= '0;
        tally    <= '0;
      end else begin
        vote_idx <= vote_idx + 1'b1;
        tally    <= tally_next;
      end
    end
  end
`else
  logic unused_votes;
  assign unused_votes = (VOTES > 0);
  assign last_eval    = 1'b1;
  assign bit_val      = cmp_gt;
`endif

  // Partial response with the bit just decided merged in.
  always_comb begin
    final_vec          = result_reg;
    final_vec[bit_idx] = bit_val;
  end

  // State register.
  always_ff @(posedge clk or negedge sys_rst_neg) begin
    if (!sys_rst_neg) state <= IDLE;
    else              state <= next_state;
  end

  // Sequencing; dropping en anywhere but IDLE returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (host.en) next_state = LOAD;
      LOAD:    next_state = host.en ? CLEAR : IDLE;
      CLEAR:   next_state = host.en ? COUNT : IDLE;
      COUNT:   if (!host.en) next_state = IDLE;
               else if (win_last) next_state = CMP;
      CMP:     if (!host.en) next_state = IDLE;
               else if (last_eval && last_bit) next_state = DONE;
               else next_state = CLEAR;
      DONE:    if (!host.en) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Challenge capture, window timing, bit stepping and response update.
  always_ff @(posedge clk or negedge sys_rst_neg) begin
    if (!sys_rst_neg) begin
      chall_reg  <= '0;
      rot_amt    <= '0;
      bit_idx    <= '0;
      win_cnt    <= '0;
      result_reg <= '0;
      response   <= '0;
    end else begin
      if (state == IDLE && host.en) begin
        chall_reg  <= host.chall_in;
        rot_amt    <= '0;
        bit_idx    <= '0;
        result_reg <= '0;
      end
      if (state == CLEAR) win_cnt <= '0;
      if (state == COUNT) win_cnt <= win_cnt + 1'b1;
      if (advance) begin
        result_reg <= final_vec;
        bit_idx    <= bit_idx + 1'b1;
        rot_amt    <= (rot_amt == ROT_W'(CHAL_W - 1)) ? '0 : rot_amt + 1'b1;
        if (last_bit) response <= final_vec;
      end
    end
  end

  assign host.response = response;
  assign host.ready    = (state == DONE);
  assign host.busy     = (state == LOAD) || (state == CLEAR) ||
                         (state == COUNT) || (state == CMP);

endmodule

// File: tb/tb_ro_puf_eval.sv
// tb_ro_puf_eval: bench for ro_puf_eval with a full-width (CNT_W=8) and a
// narrow-counter (CNT_W=3) instance sharing clock, reset, oscillators and host drive.
`timescale 1ns/1ps
module tb_ro_puf_eval;

  localparam int CHAL_W = 8;
  localparam int RESP_W = 8;
  localparam int NUM_RO = 16;
  localparam int WINDOW = 64;
  localparam int VOTES  = 3;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EVALS = VOTES;
`else
  localparam int EVALS = 1;
`endif
  localparam int LATENCY  = 1 + RESP_W * EVALS * (WINDOW + 2);
  localparam int MAX_WAIT = LATENCY + 200;

  typedef struct {
    logic [7:0] chall;
    logic [7:0] exp8;
    logic [7:0] exp3;
  } vector_t;

  logic              clk = 1'b0;
  logic              sys_rst_neg;
  logic [NUM_RO-1:0] ro = '0;
  logic [NUM_RO-1:0] ro_stall = '0;
  int                ro_div [NUM_RO] = '{default: 0};
  logic              drv_en;
  logic [CHAL_W-1:0] drv_chall;
  int                stall_eval = -1;
  int                checks = 0;
  int                errors = 0;

  ro_puf_eval_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus8 ();
  ro_puf_eval_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus3 ();

  assign bus8.en       = drv_en;
  assign bus8.chall_in = drv_chall;
  assign bus3.en       = drv_en;
  assign bus3.chall_in = drv_chall;

  ro_puf_eval #(.CHAL_W(CHAL_W), .RESP_W(RESP_W), .NUM_RO(NUM_RO), .CNT_W(8),
                .WINDOW(WINDOW), .VOTES(VOTES)) dut8 (
    .clk(clk), .sys_rst_neg(sys_rst_neg), .ro_in(ro), .host(bus8)
  );

  ro_puf_eval #(.CHAL_W(CHAL_W), .RESP_W(RESP_W), .NUM_RO(NUM_RO), .CNT_W(3),
                .WINDOW(WINDOW), .VOTES(VOTES)) dut3 (
    .clk(clk), .sys_rst_neg(sys_rst_neg), .ro_in(ro), .host(bus3)
  );

  always #5 clk = ~clk;

  // Oscillator j toggles every j+2 clock cycles unless stalled.
  always @(negedge clk) begin
    for (int j = 0; j < NUM_RO; j++) begin
      if (!ro_stall[j]) begin
        if (ro_div[j] >= j + 1) begin
          ro_div[j] = 0;
          ro[j]     = ~ro[j];
        end else begin
          ro_div[j] = ro_div[j] + 1;
        end
      end
    end
  end

  // Rising edges of oscillator j seen in any WINDOW-sample span, saturated.
  function automatic int edges_lo(input int j, input int sat);
    int p;
    p = 2 * (j + 2);
    return ((WINDOW / p) < sat) ? (WINDOW / p) : sat;
  endfunction

  function automatic int edges_hi(input int j, input int sat);
    int p;
    p = 2 * (j + 2);
    return (((WINDOW + p - 1) / p) < sat) ? ((WINDOW + p - 1) / p) : sat;
  endfunction

  // Expected response and the mask of bits whose outcome does not depend on phase.
  function automatic void model_response(input logic [7:0] chall, input int cnt_w,
                                         output logic [7:0] exp_v, output logic [7:0] care);
    int c, k, a, b, sat, r;
    exp_v = '0;
    care  = '0;
    sat   = (1 << cnt_w) - 1;
    c     = int'(chall);
    for (int i = 0; i < RESP_W; i++) begin
      r = i % CHAL_W;
      k = ((c << r) | (c >> (CHAL_W - r))) & ((1 << CHAL_W) - 1);
      a = k % NUM_RO;
      b = (k / NUM_RO) % NUM_RO;
      if (a == b) b = a ^ 1;
      if (edges_lo(a, sat) > edges_hi(b, sat)) begin
        exp_v[i] = 1'b1;
        care[i]  = 1'b1;
      end else if (edges_hi(a, sat) <= edges_lo(b, sat)) begin
        care[i] = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected, input logic [31:0] mask);
    checks++;
    if ((actual & mask) !== (expected & mask)) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (mask %0h)", name, actual, expected, mask);
    end
  endtask

  // Raise en with a challenge and count cycles from the en-sample edge to ready.
  task automatic applyStimulus(input logic [CHAL_W-1:0] chall, output int latency);
    @(negedge clk);
    drv_chall = chall;
    drv_en    = 1'b1;
    @(posedge clk);
    latency = 0;
    while (latency < MAX_WAIT) begin
      @(posedge clk);
      #1;
      latency++;
      if (latency == 50) drv_chall = ~chall;
      if (stall_eval >= 0) begin
        if (latency == 1 + stall_eval * (WINDOW + 2))       ro_stall[1] = 1'b1;
        if (latency == 1 + (stall_eval + 1) * (WINDOW + 2)) ro_stall[1] = 1'b0;
      end
      if (bus8.ready) break;
    end
  endtask

  task automatic runVector(input string tag, input logic [7:0] chall,
                           input logic [7:0] exp8, input logic [7:0] care8,
                           input logic [7:0] exp3, input logic [7:0] care3);
    int lat;
    applyStimulus(chall, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(LATENCY), '1);
    checkOutput({tag, " ready3"}, 32'(bus3.ready), 32'd1, '1);
    checkOutput({tag, " busy_done"}, 32'(bus8.busy), 32'd0, '1);
    checkOutput({tag, " resp8"}, 32'(bus8.response), 32'(exp8), 32'(care8));
    checkOutput({tag, " resp3"}, 32'(bus3.response), 32'(exp3), 32'(care3));
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, " ready_hold"}, 32'(bus8.ready), 32'd1, '1);
    @(negedge clk);
    drv_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, " ready_release"}, 32'(bus8.ready), 32'd0, '1);
    checkOutput({tag, " resp8_kept"}, 32'(bus8.response), 32'(exp8), 32'(care8));
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vector_t    vectors [5];
    logic [7:0] rc, e8, m8, e3, m3;

    vectors[0] = '{chall: 8'h10, exp8: 8'h0F, exp3: 8'h0C};
    vectors[1] = '{chall: 8'h00, exp8: 8'hFF, exp3: 8'h00};
    vectors[2] = '{chall: 8'h01, exp8: 8'hF0, exp3: 8'hC0};
    vectors[3] = '{chall: 8'h21, exp8: 8'h87, exp3: 8'h86};
    vectors[4] = '{chall: 8'h10, exp8: 8'h0F, exp3: 8'h0C};

    sys_rst_neg = 1'b0;
    drv_en      = 1'b0;
    drv_chall   = '0;
    #12;
    checkOutput("reset response", 32'(bus8.response), 32'd0, '1);
    checkOutput("reset ready", 32'(bus8.ready), 32'd0, '1);
    checkOutput("reset busy", 32'(bus8.busy), 32'd0, '1);
    @(negedge clk);
    sys_rst_neg = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      runVector($sformatf("vec%0d", v), vectors[v].chall,
                vectors[v].exp8, 8'hFF, vectors[v].exp3, 8'hFF);
    end

    // Abort a 0x00 run partway; the previous 0x10 response must survive.
    @(negedge clk);
    drv_chall = 8'h00;
    drv_en    = 1'b1;
    @(posedge clk);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("abort busy_before", 32'(bus8.busy), 32'd1, '1);
    @(negedge clk);
    drv_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort ready", 32'(bus8.ready), 32'd0, '1);
    checkOutput("abort busy", 32'(bus8.busy), 32'd0, '1);
    checkOutput("abort resp8", 32'(bus8.response), 32'h0F, '1);
    checkOutput("abort resp3", 32'(bus3.response), 32'h0C, '1);
    @(negedge clk);
    runVector("rerun00", 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF);

    // Asynchronous reset in the middle of a counting window.
    @(negedge clk);
    drv_chall = 8'h21;
    drv_en    = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("midreset busy_before", 32'(bus8.busy), 32'd1, '1);
    #1;
    sys_rst_neg = 1'b0;
    drv_en      = 1'b0;
    #1;
    checkOutput("midreset resp8", 32'(bus8.response), 32'd0, '1);
    checkOutput("midreset resp3", 32'(bus3.response), 32'd0, '1);
    checkOutput("midreset ready", 32'(bus8.ready), 32'd0, '1);
    checkOutput("midreset busy", 32'(bus8.busy), 32'd0, '1);
    @(negedge clk);
    sys_rst_neg = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      rc = 8'($urandom);
      model_response(rc, 8, e8, m8);
      model_response(rc, 3, e3, m3);
      runVector($sformatf("rand%0d_%02h", r, rc), rc, e8, m8, e3, m3);
    end

`ifdef PUF_MAJORITY_VOTE_EN
    // Oscillator 1 frozen during the second vote of bit 4.
    stall_eval = 4 * VOTES + 1;
    runVector("vote_stall", 8'h10, 8'h0F, 8'hFF, 8'h0C, 8'hFF);
    stall_eval = -1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
